invol_arbiter: RTL and testbench
================================

Name: invol_arbiter

Overview:
- Shares the single response path (param_data/param_write into the response FIFO) between NUNITS command units (gpio, stepper, etc.).
- Command-driven responses come from the unit executing the current command.
- Involuntary (unsolicited) responses are granted round-robin via invol_req/invol_grant, only between commands.
- Sits between the command dispatcher, the units, and the response FIFO writer.

Parameters:
- NUNITS, 4, number of attached units (2..16).
- UNIT_BITS, $clog2(NUNITS), width of the unit index.
- TIMEOUT, 1024, grant watchdog limit in clk cycles (used only with INVOL_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- unit_param_data  in  NUNITS*33  per-unit response word; unit k occupies bits [33k+32:33k].
- unit_param_write  in  NUNITS  per-unit response strobe.
- unit_invol_req  in  NUNITS  per-unit involuntary request; level, held until done.
- unit_invol_grant  out  NUNITS  one-hot grant.
- cmd_busy  in  1  dispatcher has a command in flight (cmd_ready issued, cmd_done not yet seen).
- cmd_unit  in  UNIT_BITS  index of the unit owning the command in flight.
- invol_active  out  1  grant held or pending; dispatcher must not start a new command while high.
- param_data  out  33  muxed response word to FIFO.
- param_write  out  1  muxed strobe to FIFO.
- collision  out  1  sticky error flag.
- timeout_err  out  1  sticky watchdog flag (constant 0 without INVOL_TIMEOUT_EN).

Behaviour:
- Reset (async, rst=1):
  - state=S_CMD, rr_ptr=0, owner=0.
  - All outputs 0: grants, param_data, param_write, invol_active, collision, timeout_err.
- Output path is registered, 1-cycle latency: param_data/param_write at cycle n+1 reflect the selected unit's inputs at cycle n.
- Selected unit:
  - In S_CMD, the source is cmd_unit, gated by cmd_busy; param_write=0 when cmd_busy=0.
  - In S_GRANT, the source is the owner.
- State S_CMD:
  - If cmd_busy=0 and any unit_invol_req is set: pick the first requester at or after rr_ptr (modulo NUNITS). Register owner, set unit_invol_grant[owner]=1 and invol_active=1 on the next edge, go to S_GRANT.
  - If cmd_busy=1, requests wait.
  - If cmd_busy rises in the same cycle a grant would be chosen, the command wins; no grant is issued.
- State S_GRANT:
  - Pass the owner's param words.
  - When unit_invol_req[owner]=0: drop the grant and invol_active next edge, set rr_ptr=owner+1 (wrap to 0 at NUNITS), return to S_CMD.
  - A re-request from the same unit is considered only after all other pending requesters have been served.
- Collision:
  - Any unit_param_write bit set other than the selected unit's sets collision=1 (sticky until rst).
  - The stray word is dropped.
  - This includes any param_write while neither a command nor a grant is active.
- cmd_busy=1 while in S_GRANT is a dispatcher protocol violation: set collision, keep serving the owner.
- rst mid-grant: grant drops immediately (async). A unit must re-request after reset.
- Grants are always one-hot or zero. Never a grant change in the same cycle as the previous owner's last param_write (the drop happens one cycle after req falls).

Optional Feature:
- Macro INVOL_TIMEOUT_EN.
- With it defined:
  - A counter clears on entry to S_GRANT and increments every S_GRANT cycle.
  - Reaching TIMEOUT forces the grant off, sets timeout_err (sticky), advances rr_ptr past the owner, and returns to S_CMD.
  - A revoked owner's further param_write counts as a collision.
- Without it: no counter, timeout_err tied 0, and a grant is held indefinitely.

Decomposition:
- Shared package holds:
  - state encoding constants S_CMD=0, S_GRANT=1.
  - response word width constant PARAM_W=33.
  - the unit index assignment constants (UNIT_GPIO, UNIT_STEPPER, ...) shared with the dispatcher.
- One sub-module, rr_pick: combinational round-robin priority encoder taking req vector and rr_ptr, returning index and valid.

Test Plan:
- Single cmd response: cmd_busy=1, cmd_unit=2, unit 2 writes 0x0_1234_5678 → next cycle param_data=0x012345678, param_write=1, collision=0.
- Round robin: units 0, 1, 3 request simultaneously with cmd_busy=0, rr_ptr=0, each holding req 3 cycles → grants in order 0, 1, 3; rr_ptr ends at 0; one idle S_CMD cycle between grants.
- Command priority: req[1] rises in the same cycle as cmd_busy → no grant until cmd_busy falls; grant[1] asserts 1 cycle later.
- Collision: during grant to unit 0, unit 2 pulses param_write → word not forwarded, collision=1 and stays 1 until rst.
- Async reset mid-grant: rst asserted between edges while grant[3]=1 → grant, invol_active, param_write all 0 immediately; after release, state S_CMD, rr_ptr=0.
- Timeout (INVOL_TIMEOUT_EN, TIMEOUT=8): unit 1 holds req indefinitely → grant drops after 8 cycles, timeout_err=1, pending unit 2 granted next.

Source files
------------

// File: rtl/invol_arbiter_pkg.sv
// Shared definitions for the involuntary-response arbiter and the command dispatcher.
package invol_arbiter_pkg;

  // Arbiter FSM encoding
  typedef enum logic {
    S_CMD   = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  // Response word width: 32 data bits plus one flag bit
  localparam int unsigned PARAM_W = 33;

  // Unit index assignment, shared with the dispatcher
  localparam int unsigned UNIT_GPIO    = 0;
  localparam int unsigned UNIT_STEPPER = 1;
  localparam int unsigned UNIT_ADC     = 2;
  localparam int unsigned UNIT_PWM     = 3;

endpackage

// File: rtl/invol_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester at or after ptr, modulo NUNITS.
module invol_arbiter_rr_pick #(
  parameter int unsigned NUNITS    = 4,
  parameter int unsigned UNIT_BITS = $clog2(NUNITS)
) (
  input  logic [NUNITS-1:0]    req,
  input  logic [UNIT_BITS-1:0] ptr,
  output logic [UNIT_BITS-1:0] idx,
  output logic                 valid
);

  // Scan NUNITS positions starting at ptr, wrapping at NUNITS
  always_comb begin
    int unsigned        cand;
    logic [UNIT_BITS-1:0] cand_idx;
    idx      = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NUNITS; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NUNITS) cand = cand - NUNITS;
      cand_idx = UNIT_BITS'(cand);
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/invol_arbiter.sv
// Shares the single response path between NUNITS units. Command responses come from the
// unit owning the command in flight; unsolicited responses are granted round-robin between
// commands. Optional grant watchdog enabled by defining INVOL_TIMEOUT_EN.
module invol_arbiter
  import invol_arbiter_pkg::*;
#(
  parameter int unsigned NUNITS    = 4,
  parameter int unsigned UNIT_BITS = $clog2(NUNITS),
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUNITS*PARAM_W-1:0]   unit_param_data,
  input  logic [NUNITS-1:0]           unit_param_write,
  input  logic [NUNITS-1:0]           unit_invol_req,
  output logic [NUNITS-1:0]           unit_invol_grant,
  input  logic                        cmd_busy,
  input  logic [UNIT_BITS-1:0]        cmd_unit,
  output logic                        invol_active,
  output logic [PARAM_W-1:0]          param_data,
  output logic                        param_write,
  output logic                        collision,
  output logic                        timeout_err
);

  if (NUNITS < 2 || NUNITS > 16) begin : g_bad_nunits
    $error("invol_arbiter: NUNITS must be in 2..16");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("invol_arbiter: TIMEOUT must be at least 1");
  end

  state_e               state_q;
  logic [UNIT_BITS-1:0] owner_q;
  logic [UNIT_BITS-1:0] rr_ptr_q;
  logic [UNIT_BITS-1:0] owner_next;

  logic [UNIT_BITS-1:0] pick_idx;
  logic                 pick_valid;

  logic [UNIT_BITS-1:0] sel_unit;
  logic                 sel_valid;
  logic [NUNITS-1:0]    sel_mask;
  logic [PARAM_W-1:0]   sel_word;
  logic                 sel_write;

  invol_arbiter_rr_pick #(
    .NUNITS    (NUNITS),
    .UNIT_BITS (UNIT_BITS)
  ) u_rr_pick (
    .req   (unit_invol_req),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Pointer value that puts the current owner last in the next round
  assign owner_next = (owner_q == UNIT_BITS'(NUNITS - 1)) ? '0 : owner_q + 1'b1;

  // Select the unit allowed to drive the response path this cycle
  always_comb begin
    sel_unit  = (state_q == S_GRANT) ? owner_q : cmd_unit;
    sel_valid = (state_q == S_GRANT) || cmd_busy;
    sel_mask  = '0;
    sel_word  = '0;
    sel_write = 1'b0;
    for (int unsigned k = 0; k < NUNITS; k++) begin
      if (sel_valid && sel_unit == UNIT_BITS'(k)) begin
        sel_mask[k] = 1'b1;
        sel_word    = unit_param_data[k*PARAM_W +: PARAM_W];
        sel_write   = unit_param_write[k];
      end
    end
  end

`ifdef INVOL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Arbitration FSM with registered grant, active and watchdog outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_CMD;
      owner_q          <= '0;
      rr_ptr_q         <= '0;
      unit_invol_grant <= '0;
      invol_active     <= 1'b0;
`ifdef INVOL_TIMEOUT_EN
      tmo_cnt_q        <= '0;
      timeout_err      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_CMD: begin
          // A command starting this cycle wins over a pending grant
          if (!cmd_busy && pick_valid) begin
            owner_q          <= pick_idx;
            unit_invol_grant <= NUNITS'(1) << pick_idx;
            invol_active     <= 1'b1;
            state_q          <= S_GRANT;
`ifdef INVOL_TIMEOUT_EN
            tmo_cnt_q        <= '0;
`endif
          end
        end
        S_GRANT: begin
`ifdef INVOL_TIMEOUT_EN
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
          if (!unit_invol_req[owner_q]) begin
            unit_invol_grant <= '0;
            invol_active     <= 1'b0;
            rr_ptr_q         <= owner_next;
            state_q          <= S_CMD;
          end
`ifdef INVOL_TIMEOUT_EN
          else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            unit_invol_grant <= '0;
            invol_active     <= 1'b0;
            rr_ptr_q         <= owner_next;
            state_q          <= S_CMD;
            timeout_err      <= 1'b1;
          end
`endif
        end
        default: state_q <= S_CMD;
      endcase
    end
  end

  // Registered response path and sticky collision detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      param_data  <= '0;
      param_write <= 1'b0;
      collision   <= 1'b0;
    end else begin
      param_write <= sel_write;
      param_data  <= sel_write ? sel_word : '0;
      // Strobes from unselected units are dropped; a command during a grant is a protocol error
      if ((|(unit_param_write & ~sel_mask)) || (state_q == S_GRANT && cmd_busy)) begin
        collision <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_invol_arbiter.sv
// Directed bench for invol_arbiter: table-driven command-path vectors plus hand-written
// sequences for round-robin, command priority, collision, async reset and the watchdog.
module tb_invol_arbiter;
  import invol_arbiter_pkg::*;

  localparam int unsigned N = 4;

  logic             clk;
  logic             rst;
  logic [N*33-1:0]  unit_param_data;
  logic [N-1:0]     unit_param_write;
  logic [N-1:0]     unit_invol_req;
  logic [N-1:0]     unit_invol_grant;
  logic             cmd_busy;
  logic [1:0]       cmd_unit;
  logic             invol_active;
  logic [32:0]      param_data;
  logic             param_write;
  logic             collision;
  logic             timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  invol_arbiter #(
    .NUNITS  (N),
    .TIMEOUT (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .unit_param_data  (unit_param_data),
    .unit_param_write (unit_param_write),
    .unit_invol_req   (unit_invol_req),
    .unit_invol_grant (unit_invol_grant),
    .cmd_busy         (cmd_busy),
    .cmd_unit         (cmd_unit),
    .invol_active     (invol_active),
    .param_data       (param_data),
    .param_write      (param_write),
    .collision        (collision),
    .timeout_err      (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         busy;
    logic [1:0]   unit;
    logic [3:0]   wr;
    logic [131:0] data;
    logic [32:0]  exp_pd;
    logic         exp_pw;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int order [3];
    int held;
    int w;
    int u;
    logic [32:0] word;

    order[0] = UNIT_GPIO;
    order[1] = UNIT_STEPPER;
    order[2] = UNIT_PWM;

    // Unselected units carry distinct junk so a wrong mux selection is visible
    vecs[0] = '{1'b1, 2'(UNIT_ADC), 4'b0100,
                {33'h0_AAAA_0003, 33'h0_1234_5678, 33'h0_AAAA_0001, 33'h0_AAAA_0000},
                33'h0_1234_5678, 1'b1};
    vecs[1] = '{1'b1, 2'(UNIT_GPIO), 4'b0001,
                {33'h0_BBBB_0003, 33'h0_BBBB_0002, 33'h0_BBBB_0001, 33'h1_DEAD_BEEF},
                33'h1_DEAD_BEEF, 1'b1};
    vecs[2] = '{1'b1, 2'(UNIT_PWM), 4'b0000,
                {33'h1_CCCC_0003, 33'h0_CCCC_0002, 33'h0_CCCC_0001, 33'h0_CCCC_0000},
                33'h0, 1'b0};
    vecs[3] = '{1'b1, 2'(UNIT_STEPPER), 4'b0010,
                {33'h0_DDDD_0003, 33'h0_DDDD_0002, 33'h1_FFFF_FFFF, 33'h0_DDDD_0000},
                33'h1_FFFF_FFFF, 1'b1};
    vecs[4] = '{1'b1, 2'(UNIT_PWM), 4'b1000,
                {33'h0_0000_0001, 33'h1_EEEE_0002, 33'h1_EEEE_0001, 33'h1_EEEE_0000},
                33'h0_0000_0001, 1'b1};

    rst              = 1'b1;
    unit_param_data  = '0;
    unit_param_write = '0;
    unit_invol_req   = '0;
    cmd_busy         = 1'b0;
    cmd_unit         = '0;
    tick();
    tick();

    check("rst_grant", 64'(unit_invol_grant), 64'h0);
    check("rst_active", 64'(invol_active), 64'h0);
    check("rst_pd", 64'(param_data), 64'h0);
    check("rst_pw", 64'(param_write), 64'h0);
    check("rst_collision", 64'(collision), 64'h0);
    check("rst_timeout", 64'(timeout_err), 64'h0);
    rst = 1'b0;
    tick();

    // Command-driven responses
    for (int i = 0; i < 5; i++) begin
      cmd_busy         = vecs[i].busy;
      cmd_unit         = vecs[i].unit;
      unit_param_write = vecs[i].wr;
      unit_param_data  = vecs[i].data;
      tick();
      check($sformatf("vec%0d_pw", i), 64'(param_write), 64'(vecs[i].exp_pw));
      if (vecs[i].exp_pw) check($sformatf("vec%0d_pd", i), 64'(param_data), 64'(vecs[i].exp_pd));
      check($sformatf("vec%0d_collision", i), 64'(collision), 64'h0);
    end
    cmd_busy         = 1'b0;
    unit_param_write = '0;
    unit_param_data  = '0;
    tick();

    // Round robin among units 0, 1, 3 with one idle cycle between grants
    unit_invol_req = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      u = order[i];
      w = 0;
      do begin
        tick();
        w++;
      end while (unit_invol_grant == 4'b0 && w < 10);
      check($sformatf("rr%0d_wait", i), 64'(w), 64'd1);
      check($sformatf("rr%0d_grant", i), 64'(unit_invol_grant), 64'(4'b0001 << u));
      check($sformatf("rr%0d_active", i), 64'(invol_active), 64'h1);
      word = 33'h1_A5A5_0000 + 33'(u);
      unit_param_data[u*33 +: 33] = word;
      unit_param_write[u]         = 1'b1;
      tick();
      unit_param_write = '0;
      check($sformatf("rr%0d_pw", i), 64'(param_write), 64'h1);
      check($sformatf("rr%0d_pd", i), 64'(param_data), 64'(word));
      tick();
      tick();
      check($sformatf("rr%0d_hold", i), 64'(unit_invol_grant), 64'(4'b0001 << u));
      unit_invol_req[u] = 1'b0;
      tick();
      check($sformatf("rr%0d_drop", i), 64'(unit_invol_grant), 64'h0);
      check($sformatf("rr%0d_inactive", i), 64'(invol_active), 64'h0);
    end
    // Pointer wrapped to 0 after serving unit 3
    unit_invol_req = 4'b0011;
    tick();
    check("rr_ptr_wrap", 64'(unit_invol_grant), 64'b0001);
    unit_invol_req = '0;
    tick();
    tick();

    // Command raised together with a request: command wins
    cmd_busy                     = 1'b1;
    cmd_unit                     = 2'(UNIT_ADC);
    unit_invol_req[UNIT_STEPPER] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("prio_wait%0d", i), 64'(unit_invol_grant), 64'h0);
    end
    cmd_busy = 1'b0;
    tick();
    check("prio_grant", 64'(unit_invol_grant), 64'b0010);
    unit_invol_req = '0;
    tick();
    tick();
    check("prio_no_collision", 64'(collision), 64'h0);

    // Stray write from unit 2 during grant to unit 0
    unit_invol_req[UNIT_GPIO] = 1'b1;
    tick();
    check("col_grant", 64'(unit_invol_grant), 64'b0001);
    unit_param_data[UNIT_ADC*33 +: 33] = 33'h0_BAD0_BAD0;
    unit_param_write[UNIT_ADC]         = 1'b1;
    tick();
    unit_param_write = '0;
    check("col_dropped", 64'(param_write), 64'h0);
    check("col_set", 64'(collision), 64'h1);
    tick();
    tick();
    check("col_sticky", 64'(collision), 64'h1);
    unit_invol_req = '0;
    tick();
    tick();

    // Asynchronous reset while unit 3 holds the grant and is writing
    unit_invol_req[UNIT_PWM] = 1'b1;
    tick();
    check("arst_grant", 64'(unit_invol_grant), 64'b1000);
    unit_param_write[UNIT_PWM] = 1'b1;
    tick();
    check("arst_pw_before", 64'(param_write), 64'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_grant_off", 64'(unit_invol_grant), 64'h0);
    check("arst_active_off", 64'(invol_active), 64'h0);
    check("arst_pw_off", 64'(param_write), 64'h0);
    check("arst_collision_clr", 64'(collision), 64'h0);
    unit_invol_req   = '0;
    unit_param_write = '0;
    tick();
    rst = 1'b0;
    tick();
    check("arst_idle", 64'(unit_invol_grant), 64'h0);
    // rr_ptr was 1 before reset; back at 0 unit 0 must beat unit 3
    unit_invol_req = 4'b1001;
    tick();
    check("arst_rr_ptr", 64'(unit_invol_grant), 64'b0001);

    // Command during a grant: flagged, owner still served
    unit_invol_req                      = 4'b0001;
    cmd_busy                            = 1'b1;
    cmd_unit                            = 2'(UNIT_ADC);
    unit_param_data[UNIT_GPIO*33 +: 33] = 33'h0_0BAD_C0DE;
    unit_param_write[UNIT_GPIO]         = 1'b1;
    tick();
    unit_param_write = '0;
    cmd_busy         = 1'b0;
    check("viol_pw", 64'(param_write), 64'h1);
    check("viol_pd", 64'(param_data), 64'h0_0BAD_C0DE);
    check("viol_collision", 64'(collision), 64'h1);
    check("viol_grant", 64'(unit_invol_grant), 64'b0001);
    unit_invol_req = '0;
    tick();
    do_reset();

    // Write with neither command nor grant active
    check("idle_col_clear", 64'(collision), 64'h0);
    unit_param_write[UNIT_STEPPER] = 1'b1;
    tick();
    unit_param_write = '0;
    check("idle_pw", 64'(param_write), 64'h0);
    check("idle_collision", 64'(collision), 64'h1);
    do_reset();

    // Watchdog: unit 1 holds its request indefinitely, unit 2 pending
    unit_invol_req = 4'b0110;
    tick();
    check("tmo_grant", 64'(unit_invol_grant), 64'b0010);
    held = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (unit_invol_grant == 4'b0010) held++;
      else break;
    end
`ifdef INVOL_TIMEOUT_EN
    check("tmo_held", 64'(held), 64'd8);
    check("tmo_err", 64'(timeout_err), 64'h1);
    check("tmo_active_off", 64'(invol_active), 64'h0);
    tick();
    check("tmo_next_grant", 64'(unit_invol_grant), 64'b0100);
`else
    check("tmo_held", 64'(held), 64'd41);
    check("tmo_err", 64'(timeout_err), 64'h0);
    check("tmo_still_granted", 64'(unit_invol_grant), 64'b0010);
`endif
    unit_invol_req = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
